folded_majority_seq: RTL and testbench



---
 rtl/folded_majority_seq_if.sv | 24 ++
 rtl/folded_majority_seq.sv | 67 ++++++
 tb/tb_folded_majority_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/folded_majority_seq_if.sv
// folded_majority_seq_if: request/result handshake bundle for the folded majority block.
interface folded_majority_seq_if #(
   parameter int N  = 127,
   parameter int CW = $clog2(N + 1)
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic          thr_mode;
   logic [CW-1:0] thr_value;
   logic          out_valid;
   logic          out_ready;
   logic          out_y;
   logic [CW-1:0] out_count;
   logic          busy;
   modport master (
      output in_valid, in_data, thr_mode, thr_value, out_ready,
      input  in_ready, out_valid, out_y, out_count, busy
   );
   modport slave (
      input  in_valid, in_data, thr_mode, thr_value, out_ready,
      output in_ready, out_valid, out_y, out_count, busy
   );
endinterface

// File: rtl/folded_majority_seq.sv
// folded_majority_seq: majority/threshold vote folded over NCHUNK cycles of W-bit popcounts.
module folded_majority_seq #(
   parameter int N  = 127,
   parameter int W  = 16,
   parameter int CW = $clog2(N + 1)
) (
   input logic                 clk,
   input logic                 rst_n,
   folded_majority_seq_if.slave bus
);
   localparam int NCHUNK = (N + W - 1) / W;
   localparam int KW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam int PW     = NCHUNK * W;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t        r_state, w_next;
   logic [PW-1:0] r_data;
   logic [CW-1:0] r_thr, r_acc, r_cnt, w_sum;
   logic [KW-1:0] r_k;
   logic          r_y, w_last;
   function automatic logic [CW-1:0] f_pop(input logic [W-1:0] v);
      f_pop = '0;
      for (int i = 0; i < W; i++) f_pop = f_pop + CW'(v[i]);
   endfunction
   assign w_sum  = r_acc + f_pop(r_data[W-1:0]);
   assign w_last = r_k == KW'(NCHUNK - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE  && bus.in_valid)  ? ACCUM :
               (r_state == ACCUM && w_last)        ? DONE  :
               (r_state == DONE  && bus.out_ready) ? IDLE  : r_state;
   end
   // Data shifts right each cycle so the active chunk is always at the bottom;
   // zero-extension on load supplies the padding of the final chunk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_thr  <= '0;
         r_acc  <= '0;
         r_k    <= '0;
         r_cnt  <= '0;
         r_y    <= 1'b0;
      end else if (r_state == IDLE && bus.in_valid) begin
         r_data <= PW'(bus.in_data);
         r_thr  <= bus.thr_mode ? bus.thr_value : CW'(N / 2 + 1);
         r_acc  <= '0;
         r_k    <= '0;
         r_cnt  <= '0;
         r_y    <= 1'b0;
      end else if (r_state == ACCUM) begin
         r_acc  <= w_sum;
         r_data <= r_data >> W;
         r_k    <= r_k + 1'b1;
         if (w_last) begin
            r_cnt <= w_sum;
            r_y   <= w_sum >= r_thr;
         end
      end
   end
   assign bus.in_ready  = r_state == IDLE;
   assign bus.busy      = r_state != IDLE;
   assign bus.out_valid = r_state == DONE;
   assign bus.out_y     = r_y;
   assign bus.out_count = r_cnt;
endmodule

// File: tb/tb_folded_majority_seq.sv
// tb_folded_majority_seq: directed checks of the folded majority block on three parameter sets.
module tb_folded_majority_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   folded_majority_seq_if #(.N(127)) a ();
   folded_majority_seq_if #(.N(9))   b ();
   folded_majority_seq_if #(.N(7))   c ();
   folded_majority_seq #(.N(127), .W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   folded_majority_seq #(.N(9),   .W(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(b));
   folded_majority_seq #(.N(7),   .W(7))  u_c (.clk(clk), .rst_n(rst_n), .bus(c));
   function automatic logic get_valid(input int sel);
      return sel == 0 ? a.out_valid : sel == 1 ? b.out_valid : c.out_valid;
   endfunction
   function automatic logic get_ready(input int sel);
      return sel == 0 ? a.in_ready : sel == 1 ? b.in_ready : c.in_ready;
   endfunction
   function automatic int get_count(input int sel);
      return sel == 0 ? int'(a.out_count) : sel == 1 ? int'(b.out_count) : int'(c.out_count);
   endfunction
   function automatic logic get_y(input int sel);
      return sel == 0 ? a.out_y : sel == 1 ? b.out_y : c.out_y;
   endfunction
   task automatic drive(input int sel, input logic v, input logic [127:0] d, input logic m, input int thr);
      case (sel)
         0: begin a.in_valid = v; a.in_data = d[126:0]; a.thr_mode = m; a.thr_value = 7'(thr); end
         1: begin b.in_valid = v; b.in_data = d[8:0];   b.thr_mode = m; b.thr_value = 4'(thr); end
         default: begin c.in_valid = v; c.in_data = d[6:0]; c.thr_mode = m; c.thr_value = 3'(thr); end
      endcase
   endtask
   task automatic set_oready(input int sel, input logic r);
      case (sel)
         0: a.out_ready = r;
         1: b.out_ready = r;
         default: c.out_ready = r;
      endcase
   endtask
   // Accepts one request, scrambles inputs after the accept edge, waits for out_valid.
   task automatic do_req(input int sel, input logic [127:0] d, input logic m, input int thr,
                         output int lat, output int cnt, output logic y);
      @(negedge clk);
      drive(sel, 1'b1, d, m, thr);
      @(negedge clk);
      drive(sel, 1'b0, ~d, ~m, thr + 37);
      lat = 0;
      while (!get_valid(sel) && lat < 300) begin
         @(negedge clk);
         lat++;
      end
      cnt = get_count(sel);
      y   = get_y(sel);
   endtask
   task automatic release_out(input int sel);
      set_oready(sel, 1'b1);
      @(negedge clk);
      set_oready(sel, 1'b0);
   endtask
   task automatic test_reset;
      checks += 5;
      if (a.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", a.in_ready); end
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a.out_valid); end
      if (a.out_y !== 1'b0)     begin errors++; $display("FAIL reset_out_y got %b want 0", a.out_y); end
      if (a.out_count !== 7'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", a.out_count); end
      if (a.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", a.busy); end
   endtask
   task automatic test_majority;
      int lat, cnt;
      logic y;
      logic [127:0] d;
      d = {64'd0, {64{1'b1}}};
      do_req(0, d, 1'b0, 0, lat, cnt, y);
      checks += 3;
      if (lat != 8)     begin errors++; $display("FAIL maj64_latency got %0d want 8", lat); end
      if (cnt != 64)    begin errors++; $display("FAIL maj64_count got %0d want 64", cnt); end
      if (y !== 1'b1)   begin errors++; $display("FAIL maj64_y got %b want 1", y); end
      release_out(0);
      checks += 2;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL maj64_drop got %b want 0", a.out_valid); end
      if (a.in_ready !== 1'b1)  begin errors++; $display("FAIL maj64_ready got %b want 1", a.in_ready); end
      d = {65'd0, {63{1'b1}}};
      do_req(0, d, 1'b0, 0, lat, cnt, y);
      checks += 2;
      if (cnt != 63)    begin errors++; $display("FAIL maj63_count got %0d want 63", cnt); end
      if (y !== 1'b0)   begin errors++; $display("FAIL maj63_y got %b want 0", y); end
      release_out(0);
   endtask
   task automatic test_threshold;
      int lat, cnt;
      logic y;
      logic [127:0] ones;
      ones = {128{1'b1}};
      do_req(0, ones, 1'b1, 100, lat, cnt, y);
      checks += 2;
      if (cnt != 127)   begin errors++; $display("FAIL thr100_count got %0d want 127", cnt); end
      if (y !== 1'b1)   begin errors++; $display("FAIL thr100_y got %b want 1", y); end
      release_out(0);
      do_req(0, '0, 1'b1, 0, lat, cnt, y);
      checks += 2;
      if (cnt != 0)     begin errors++; $display("FAIL thr0_count got %0d want 0", cnt); end
      if (y !== 1'b1)   begin errors++; $display("FAIL thr0_y got %b want 1", y); end
      release_out(0);
      do_req(0, ones ^ 128'd1, 1'b1, 127, lat, cnt, y);
      checks += 2;
      if (cnt != 126)   begin errors++; $display("FAIL thr127_count got %0d want 126", cnt); end
      if (y !== 1'b0)   begin errors++; $display("FAIL thr127_y got %b want 0", y); end
      release_out(0);
   endtask
   task automatic test_padding;
      int lat, cnt;
      logic y;
      do_req(0, 128'd1 << 126, 1'b0, 0, lat, cnt, y);
      checks += 2;
      if (cnt != 1)     begin errors++; $display("FAIL pad_count got %0d want 1", cnt); end
      if (y !== 1'b0)   begin errors++; $display("FAIL pad_y got %b want 0", y); end
      release_out(0);
   endtask
   task automatic test_backpressure;
      int lat, cnt;
      logic y;
      do_req(0, 128'h0F0F_0000_FFFF_0000_0000_00FF_0000_0001, 1'b0, 0, lat, cnt, y);
      checks += 2;
      if (cnt != 33)    begin errors++; $display("FAIL bp_count got %0d want 33", cnt); end
      if (y !== 1'b0)   begin errors++; $display("FAIL bp_y got %b want 0", y); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks += 4;
         if (a.out_valid !== 1'b1)  begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, a.out_valid); end
         if (a.out_count !== 7'd33) begin errors++; $display("FAIL bp_hold_count cyc %0d got %0d want 33", i, a.out_count); end
         if (a.in_ready !== 1'b0)   begin errors++; $display("FAIL bp_hold_ready cyc %0d got %b want 0", i, a.in_ready); end
         if (a.busy !== 1'b1)       begin errors++; $display("FAIL bp_hold_busy cyc %0d got %b want 1", i, a.busy); end
      end
      release_out(0);
      checks += 3;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", a.out_valid); end
      if (a.in_ready !== 1'b1)  begin errors++; $display("FAIL bp_ready got %b want 1", a.in_ready); end
      if (a.busy !== 1'b0)      begin errors++; $display("FAIL bp_busy got %b want 0", a.busy); end
   endtask
   task automatic test_reset_mid;
      int lat, cnt, seen;
      logic y;
      @(negedge clk);
      drive(0, 1'b1, {128{1'b1}}, 1'b0, 0);
      @(negedge clk);
      drive(0, 1'b0, '0, 1'b0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (a.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", a.out_valid); end
      if (a.in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready got %b want 1", a.in_ready); end
      if (a.busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b want 0", a.busy); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (a.out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rstmid_no_result got %0d pulses want 0", seen); end
      do_req(0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 0, lat, cnt, y);
      checks += 3;
      if (lat != 8)   begin errors++; $display("FAIL rstmid_next_latency got %0d want 8", lat); end
      if (cnt != 80)  begin errors++; $display("FAIL rstmid_next_count got %0d want 80", cnt); end
      if (y !== 1'b1) begin errors++; $display("FAIL rstmid_next_y got %b want 1", y); end
      release_out(0);
   endtask
   task automatic test_small;
      int lat, cnt;
      logic y;
      do_req(1, 128'h1FF, 1'b1, 10, lat, cnt, y);
      checks += 3;
      if (lat != 3)   begin errors++; $display("FAIL n9_latency got %0d want 3", lat); end
      if (cnt != 9)   begin errors++; $display("FAIL n9_thr10_count got %0d want 9", cnt); end
      if (y !== 1'b0) begin errors++; $display("FAIL n9_thr10_y got %b want 0", y); end
      release_out(1);
      do_req(1, 128'h01F, 1'b0, 0, lat, cnt, y);
      checks += 2;
      if (cnt != 5)   begin errors++; $display("FAIL n9_maj5_count got %0d want 5", cnt); end
      if (y !== 1'b1) begin errors++; $display("FAIL n9_maj5_y got %b want 1", y); end
      release_out(1);
      do_req(1, 128'h00F, 1'b0, 0, lat, cnt, y);
      checks += 1;
      if (y !== 1'b0) begin errors++; $display("FAIL n9_maj4_y got %b want 0", y); end
      release_out(1);
      do_req(1, 128'h100, 1'b0, 0, lat, cnt, y);
      checks += 1;
      if (cnt != 1)   begin errors++; $display("FAIL n9_pad_count got %0d want 1", cnt); end
      release_out(1);
   endtask
   task automatic test_degenerate;
      int lat, cnt;
      logic y;
      do_req(2, 128'h55, 1'b0, 0, lat, cnt, y);
      checks += 3;
      if (lat != 1)   begin errors++; $display("FAIL w_eq_n_latency got %0d want 1", lat); end
      if (cnt != 4)   begin errors++; $display("FAIL w_eq_n_count got %0d want 4", cnt); end
      if (y !== 1'b1) begin errors++; $display("FAIL w_eq_n_y got %b want 1", y); end
      release_out(2);
      do_req(2, 128'h15, 1'b0, 0, lat, cnt, y);
      checks += 2;
      if (cnt != 3)   begin errors++; $display("FAIL w_eq_n_3_count got %0d want 3", cnt); end
      if (y !== 1'b0) begin errors++; $display("FAIL w_eq_n_3_y got %b want 0", y); end
      release_out(2);
   endtask
   task automatic test_random;
      int lat, cnt, thr, exp_cnt;
      logic y, m, exp_y;
      logic [127:0] d;
      for (int i = 0; i < 200; i++) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         thr = $urandom_range(0, 127);
         m   = 1'($urandom_range(0, 1));
         exp_cnt = $countones(d[126:0]);
         exp_y   = exp_cnt >= (m ? thr : 64);
         do_req(0, d, m, thr, lat, cnt, y);
         checks += 2;
         if (cnt != exp_cnt) begin errors++; $display("FAIL rand_count iter %0d got %0d want %0d", i, cnt, exp_cnt); end
         if (y !== exp_y)    begin errors++; $display("FAIL rand_y iter %0d got %b want %b", i, y, exp_y); end
         release_out(0);
      end
   endtask
   initial begin
      for (int s = 0; s < 3; s++) begin
         drive(s, 1'b0, '0, 1'b0, 0);
         set_oready(s, 1'b0);
      end
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset;
      test_majority;
      test_threshold;
      test_padding;
      test_backpressure;
      test_reset_mid;
      test_small;
      test_degenerate;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
